// File: rtl/ps2_host_tx_if.sv
// Command-side handshake between the command sequencer and the PS/2 host
// transmitter: one byte request in, ready/busy status and done/err pulses out.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;

  // Sequencer side: issues requests, watches status.
  modport master (
    output tx_data, tx_start,
    input  tx_ready, busy, done, err
  );

  // Transmitter side: accepts requests, reports status.
  modport slave (
    input  tx_data, tx_start,
    output tx_ready, busy, done, err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Inhibits the bus, issues a request-to-send,
// then shifts one byte (LSB first, odd parity, stop) out on the device-generated
// clock and checks the device ACK. PS/2 lines are open-drain: the outputs are
// pull-low enables. busy lets the top level blank the shared receiver.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES   = 12000,
  parameter int unsigned START_TMO_CYCLES = 1500000,
  parameter int unsigned BIT_TMO_CYCLES   = 200000,
  parameter int unsigned FILTER_CYCLES    = 4
) (
  input  logic          clk,
  input  logic          rst,          // asynchronous, active-low
  ps2_host_tx_if.slave  host,
  input  logic          ps2_clk_i,
  input  logic          ps2_data_i,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe
);

  localparam int unsigned FW = $clog2(FILTER_CYCLES + 1);
  localparam logic [FW-1:0] FLT_LAST   = FW'(FILTER_CYCLES - 1);
  localparam logic [31:0]   INH_LAST   = 32'(INHIBIT_CYCLES - 1);
  localparam logic [31:0]   START_LAST = 32'(START_TMO_CYCLES - 1);
  localparam logic [31:0]   BIT_LAST   = 32'(BIT_TMO_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_WAIT1, S_SHIFT, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
  } state_t;

  state_t state_q, state_d;

  // Index 0 = PS2Clk, index 1 = PS2Data.
  logic [1:0]    sync1_q, sync2_q, filt_q;
  logic [FW-1:0] flt_cnt_q [2];
  logic          clk_prev_q;
  logic          fall;

  logic [31:0]   timer_q;
  logic [3:0]    bit_cnt_q;
  logic [9:0]    frame_q;     // {stop, parity, data[7:0]}, shifted out from bit 0
  logic          data_drv_q;  // pull-low request for the bit currently on the wire

  // Synchronize both lines, then accept a new level only after it has been
  // stable for FILTER_CYCLES clocks; idle bus level is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      filt_q     <= '1;
      clk_prev_q <= 1'b1;
      for (int i = 0; i < 2; i++) flt_cnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the pre-edge
      // value, so the two synchronizer stages really are two stages.
      sync1_q    <= {ps2_data_i, ps2_clk_i};
      sync2_q    <= sync1_q;
      clk_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          flt_cnt_q[i] <= '0;
        end else if (flt_cnt_q[i] == FLT_LAST) begin
          filt_q[i]    <= sync2_q[i];
          flt_cnt_q[i] <= '0;
        end else begin
          flt_cnt_q[i] <= flt_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign fall = clk_prev_q & ~filt_q[0];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and Moore outputs.
  always_comb begin
    // NOTE: every output and state_d gets a default first so no path through
    // the case statement can leave a latch behind.
    state_d       = state_q;
    host.tx_ready = 1'b0;
    host.busy     = 1'b1;
    host.done     = 1'b0;
    host.err      = 1'b0;
    ps2_clk_oe    = 1'b0;
    ps2_data_oe   = 1'b0;
    case (state_q)
      S_IDLE: begin
        host.tx_ready = 1'b1;
        host.busy     = 1'b0;
        if (host.tx_start) state_d = S_INHIBIT;
      end
      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (timer_q >= INH_LAST) state_d = S_REQ;
      end
      S_REQ: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        state_d     = S_WAIT1;
      end
      S_WAIT1: begin
        ps2_data_oe = 1'b1;
        if (fall)                       state_d = S_SHIFT;
        else if (timer_q >= START_LAST) state_d = S_ERR;
      end
      S_SHIFT: begin
        ps2_data_oe = data_drv_q;
        if (fall) begin
          if (bit_cnt_q == 4'd9) state_d = S_ACK;
        end else if (timer_q >= BIT_LAST) begin
          state_d = S_ERR;
        end
      end
      S_ACK: begin
        if (fall)                     state_d = filt_q[1] ? S_ERR : S_WAIT_IDLE;
        else if (timer_q >= BIT_LAST) state_d = S_ERR;
      end
      S_WAIT_IDLE: begin
        if (filt_q == 2'b11)          state_d = S_DONE;
        else if (timer_q >= BIT_LAST) state_d = S_ERR;
      end
      S_DONE: begin
        host.done = 1'b1;
        state_d   = S_IDLE;
      end
      S_ERR: begin
        host.err = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Phase timer, byte latch and bit shifter. The timer restarts on every
  // state change and, once the device is clocking, on every falling edge;
  // falls during INHIBIT/REQ are our own and must not disturb it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      frame_q    <= '0;
      data_drv_q <= 1'b0;
    end else begin
      if ((state_d != state_q) ||
          (fall && (state_q inside {S_SHIFT, S_ACK, S_WAIT_IDLE}))) begin
        timer_q <= '0;
      end else if (timer_q != '1) begin
        timer_q <= timer_q + 1'b1;
      end

      if (state_q == S_IDLE && host.tx_start) begin
        frame_q   <= {1'b1, ~^host.tx_data, host.tx_data};
        bit_cnt_q <= '0;
      end else if (fall && (state_q == S_WAIT1 || state_q == S_SHIFT)) begin
        data_drv_q <= ~frame_q[0];
        frame_q    <= {1'b1, frame_q[9:1]};
        bit_cnt_q  <= bit_cnt_q + 1'b1;
      end
    end
  end

endmodule
